// File: rtl/divide_iter_module.sv
// divide_iter_module: signed fixed-point iterative restoring divider.
// Optional macro DIVIDE_ITER_ROUND_EN selects round-half-away-from-zero.
module divide_iter_module #(
    parameter int Q_BITS    = 10,
    parameter int D_WIDTH   = 32,
    parameter int STEPS     = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [D_WIDTH-1:0]   dividend,
    input  logic [D_WIDTH-1:0]   divisor,
    input  logic [TAG_WIDTH-1:0] tag_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [D_WIDTH-1:0]   quotient,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 div_by_zero,
    output logic                 overflow,
    output logic                 valid_out,
    input  logic                 ready_out
);

    localparam int N    = D_WIDTH + Q_BITS;
    localparam int ITER = (N + STEPS - 1) / STEPS;
    localparam int QW   = ITER * STEPS;
    localparam int NUMW = N + 1;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [D_WIDTH-1:0] POS_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam logic [D_WIDTH-1:0] NEG_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [N-1:0] POS_LIM = N'(POS_MAX);
    localparam logic [N-1:0] NEG_LIM = N'(NEG_MIN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [D_WIDTH:0]       rem_q, rem_d;
    logic [QW-1:0]          num_q, num_d;
    logic [D_WIDTH:0]       dmag_q, dmag_d;
    logic                   neg_q, neg_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [D_WIDTH-1:0]     quot_q, quot_d;
    logic [TAG_WIDTH-1:0]   tago_q, tago_d;
    logic                   dbz_q, dbz_d;
    logic                   ovf_q, ovf_d;
    logic                   vld_q, vld_d;

    logic                   sa, sb;
    logic [D_WIDTH:0]       a_ext, b_ext, amag, bmag;
    logic [NUMW-1:0]        num_init;
    logic [D_WIDTH:0]       rem_w;
    logic [QW-1:0]          num_w;
    logic [N-1:0]           mag;
    logic [D_WIDTH-1:0]     fix_q;
    logic                   fix_ovf;

    // Operand magnitudes and the starting numerator.
    always_comb begin
        sa       = dividend[D_WIDTH-1];
        sb       = divisor[D_WIDTH-1];
        a_ext    = {sa, dividend};
        b_ext    = {sb, divisor};
        amag     = sa ? (~a_ext + 1'b1) : a_ext;
        bmag     = sb ? (~b_ext + 1'b1) : b_ext;
`ifdef DIVIDE_ITER_ROUND_EN
        num_init = (NUMW'(amag) << Q_BITS) + NUMW'(bmag >> 1);
`else
        num_init = NUMW'(amag) << Q_BITS;
`endif
    end

    // STEPS restoring-division steps, MSB first, plus sign/saturation fixup.
    always_comb begin
        rem_w = rem_q;
        num_w = num_q;
        for (int i = 0; i < STEPS; i++) begin
            rem_w = {rem_w[D_WIDTH-1:0], num_w[QW-1]};
            num_w = {num_w[QW-2:0], 1'b0};
            if (rem_w >= dmag_q) begin
                rem_w    = rem_w - dmag_q;
                num_w[0] = 1'b1;
            end
        end
        mag     = num_w[N-1:0];
        fix_q   = '0;
        fix_ovf = 1'b0;
        if (neg_q) begin
            if (mag > NEG_LIM) begin
                fix_q   = NEG_MIN;
                fix_ovf = 1'b1;
            end else begin
                fix_q = D_WIDTH'(~mag + 1'b1);
            end
        end else begin
            if (mag > POS_LIM) begin
                fix_q   = POS_MAX;
                fix_ovf = 1'b1;
            end else begin
                fix_q = mag[D_WIDTH-1:0];
            end
        end
    end

    // Control FSM and datapath next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        num_d   = num_q;
        dmag_d  = dmag_q;
        neg_d   = neg_q;
        tag_d   = tag_q;
        quot_d  = quot_q;
        tago_d  = tago_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    dmag_d = bmag;
                    neg_d  = sa ^ sb;
                    tag_d  = tag_in;
                    num_d  = QW'(num_init);
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = sa ? NEG_MIN : POS_MAX;
                        tago_d  = tag_in;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_w;
                num_d = num_w;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                    quot_d  = fix_q;
                    tago_d  = tag_q;
                    dbz_d   = 1'b0;
                    ovf_d   = fix_ovf;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (ready_out) begin
                    state_d = IDLE;
                    quot_d  = '0;
                    tago_d  = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            num_q   <= '0;
            dmag_q  <= '0;
            neg_q   <= 1'b0;
            tag_q   <= '0;
            quot_q  <= '0;
            tago_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            dmag_q  <= dmag_d;
            neg_q   <= neg_d;
            tag_q   <= tag_d;
            quot_q  <= quot_d;
            tago_q  <= tago_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign ready_in    = (state_q == IDLE);
    assign quotient    = quot_q;
    assign tag_out     = tago_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign valid_out   = vld_q;

endmodule

// File: tb/tb_divide_iter_module.sv
// tb_divide_iter_module: three divider instances (STEPS 1/2/4) on shared
// inputs, checked against an arithmetic reference model.
module tb_divide_iter_module;

    localparam int QB = 10;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] dividend, divisor;
    logic [3:0]  tag_in;
    logic        valid_in, ready_out;

    logic        ready_in  [3];
    logic [31:0] quotient  [3];
    logic [3:0]  tag_out   [3];
    logic        dbz       [3];
    logic        ovf       [3];
    logic        valid_out [3];

    int steps_of [3] = '{1, 2, 4};
    int npass = 0;
    int ntot  = 0;

    always #5 clock = ~clock;

    divide_iter_module #(.Q_BITS(10), .D_WIDTH(32), .STEPS(1), .TAG_WIDTH(4)) u1 (
        .clock(clock), .reset_n(reset_n), .dividend(dividend), .divisor(divisor),
        .tag_in(tag_in), .valid_in(valid_in), .ready_in(ready_in[0]),
        .quotient(quotient[0]), .tag_out(tag_out[0]), .div_by_zero(dbz[0]),
        .overflow(ovf[0]), .valid_out(valid_out[0]), .ready_out(ready_out));

    divide_iter_module #(.Q_BITS(10), .D_WIDTH(32), .STEPS(2), .TAG_WIDTH(4)) u2 (
        .clock(clock), .reset_n(reset_n), .dividend(dividend), .divisor(divisor),
        .tag_in(tag_in), .valid_in(valid_in), .ready_in(ready_in[1]),
        .quotient(quotient[1]), .tag_out(tag_out[1]), .div_by_zero(dbz[1]),
        .overflow(ovf[1]), .valid_out(valid_out[1]), .ready_out(ready_out));

    divide_iter_module #(.Q_BITS(10), .D_WIDTH(32), .STEPS(4), .TAG_WIDTH(4)) u4 (
        .clock(clock), .reset_n(reset_n), .dividend(dividend), .divisor(divisor),
        .tag_in(tag_in), .valid_in(valid_in), .ready_in(ready_in[2]),
        .quotient(quotient[2]), .tag_out(tag_out[2]), .div_by_zero(dbz[2]),
        .overflow(ovf[2]), .valid_out(valid_out[2]), .ready_out(ready_out));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic dz, output logic ov);
        longint sa, sb, ma, mb, num, m, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        q  = '0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = (sa < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            num = ma * (longint'(1) << QB);
`ifdef DIVIDE_ITER_ROUND_EN
            num = num + mb / 2;
`endif
            m = num / mb;
            r = ((sa < 0) != (sb < 0)) ? -m : m;
            if (r > MAXV) begin
                q  = 32'h7fff_ffff;
                ov = 1'b1;
            end else if (r < MINV) begin
                q  = 32'h8000_0000;
                ov = 1'b1;
            end else begin
                q = r[31:0];
            end
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, input int stall);
        logic [31:0] eq;
        logic        edz, eov;
        int          lat [3];
        int          e;
        int          explat;
        model(a, b, eq, edz, eov);
        lat = '{0, 0, 0};
        @(negedge clock);
        dividend = a;
        divisor  = b;
        tag_in   = t;
        valid_in = 1'b1;
        chk("ready_in_idle", 64'(ready_in[0]), 64'd1);
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        e = 1;
        for (int k = 0; k < 3; k++)
            if (valid_out[k] && lat[k] == 0) lat[k] = e;
        while ((lat[0] == 0 || lat[1] == 0 || lat[2] == 0) && e < 64) begin
            @(posedge clock);
            #1;
            e++;
            for (int k = 0; k < 3; k++)
                if (valid_out[k] && lat[k] == 0) lat[k] = e;
        end
        for (int k = 0; k < 3; k++) begin
            explat = edz ? 1 : ((42 + steps_of[k] - 1) / steps_of[k] + 1);
            chk($sformatf("latency_s%0d", steps_of[k]), 64'(lat[k]), 64'(explat));
            chk($sformatf("quotient_s%0d a=%0h b=%0h", steps_of[k], a, b),
                64'(quotient[k]), 64'(eq));
            chk($sformatf("tag_s%0d", steps_of[k]), 64'(tag_out[k]), 64'(t));
            chk($sformatf("dbz_s%0d", steps_of[k]), 64'(dbz[k]), 64'(edz));
            chk($sformatf("ovf_s%0d", steps_of[k]), 64'(ovf[k]), 64'(eov));
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            valid_in = ~valid_in;
            dividend = $urandom;
            divisor  = $urandom;
            tag_in   = 4'($urandom);
            @(posedge clock);
            #1;
            chk("stall_quotient", 64'(quotient[0]), 64'(eq));
            chk("stall_tag", 64'(tag_out[0]), 64'(t));
            chk("stall_valid", 64'(valid_out[0]), 64'd1);
            chk("stall_ready_in", 64'(ready_in[0]), 64'd0);
        end
        @(negedge clock);
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(posedge clock);
        #1;
        ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain_valid_s%0d", steps_of[k]), 64'(valid_out[k]), 64'd0);
            chk($sformatf("drain_q_s%0d", steps_of[k]), 64'(quotient[k]), 64'd0);
            chk($sformatf("drain_ready_s%0d", steps_of[k]), 64'(ready_in[k]), 64'd1);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset_n   = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tag_in    = '0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        #1;
        chk("rst_valid", 64'(valid_out[0]), 64'd0);
        chk("rst_quotient", 64'(quotient[0]), 64'd0);
        chk("rst_tag", 64'(tag_out[0]), 64'd0);
        chk("rst_flags", 64'({dbz[0], ovf[0]}), 64'd0);
        chk("rst_ready_in", 64'(ready_in[0]), 64'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        do_op(32'd3072, 32'd1536, 4'd5, 0);
        do_op(-32'sd3072, 32'd1536, 4'd1, 0);
        do_op(-32'sd3072, -32'sd1536, 4'd2, 0);
        do_op(32'd0, -32'sd1536, 4'd3, 0);
        do_op(32'd1024, 32'd0, 4'd4, 0);
        do_op(-32'sd1024, 32'd0, 4'd6, 0);
        do_op(32'h7fff_ffff, 32'd1, 4'd7, 0);
        do_op(32'h8000_0000, 32'd1024, 4'd8, 0);
        do_op(32'd2048, 32'd3072, 4'd9, 0);
        do_op(-32'sd2048, 32'd3072, 4'd10, 0);
        do_op(32'd5000, -32'sd7, 4'd11, 10);

        @(negedge clock);
        dividend = 32'd9999;
        divisor  = 32'd77;
        tag_in   = 4'd12;
        valid_in = 1'b1;
        @(posedge clock);
        #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_out[0]), 64'd0);
        chk("midrst_quotient", 64'(quotient[0]), 64'd0);
        chk("midrst_tag", 64'(tag_out[0]), 64'd0);
        chk("midrst_flags", 64'({dbz[0], ovf[0]}), 64'd0);
        chk("midrst_ready_in", 64'(ready_in[0]), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        do_op(32'd12345, 32'd321, 4'd13, 0);

        for (int i = 0; i < 12; i++) begin
            ra = 32'($signed($urandom) >>> $urandom_range(0, 30));
            rb = 32'($signed($urandom) >>> $urandom_range(0, 31));
            do_op(ra, rb, 4'($urandom), 0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
